// File: rtl/counter_ctrl.sv
// Programmable up/down counter sequencer: IDLE/RUN/HOLD/DONE with auto-reload, pause and stop.
// Optional tick prescaler compiled in with `define CNT_CTRL_PRESCALE_EN.
module counter_ctrl #(
    parameter int WIDTH     = 4,
    parameter int PRE_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 pause,
    input  logic                 mode_auto,
    input  logic                 dir_up,
    input  logic [WIDTH-1:0]     limit,
    input  logic [PRE_WIDTH-1:0] prescale,
    output logic [WIDTH-1:0]     q,
    output logic                 busy,
    output logic                 tc,
    output logic                 done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       state;
    logic             mode_lat;
    logic             dir_lat;
    logic [WIDTH-1:0] limit_lat;
    logic             tick;
    logic             at_term;
    logic             load;
    logic             run_step;

    // A (re)start is honoured only from IDLE or DONE, and stop beats it in DONE.
    assign load     = start && ((state == S_IDLE) || ((state == S_DONE) && !stop));
    // start in RUN outranks pause but does nothing itself, so counting carries on.
    assign run_step = (state == S_RUN) && !stop && !(pause && !start);
    assign at_term  = dir_lat ? (q == limit_lat) : (q == '0);

    assign busy = (state == S_RUN) || (state == S_HOLD);
    assign done = (state == S_DONE);

`ifdef CNT_CTRL_PRESCALE_EN
    logic [PRE_WIDTH-1:0] pre_cnt;
    logic [PRE_WIDTH-1:0] prescale_lat;

    assign tick = (pre_cnt == prescale_lat);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_cnt      <= '0;
            prescale_lat <= '0;
        end else if (load) begin
            pre_cnt      <= '0;
            prescale_lat <= prescale;
        end else if (stop && (state != S_IDLE)) begin
            pre_cnt <= '0;
        end else if (run_step) begin
            pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
        end
    end
`else
    logic unused_prescale;

    assign tick            = 1'b1;
    assign unused_prescale = ^prescale;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            q         <= '0;
            tc        <= 1'b0;
            mode_lat  <= 1'b0;
            dir_lat   <= 1'b0;
            limit_lat <= '0;
        end else begin
            tc <= 1'b0;
            if (load) begin
                mode_lat  <= mode_auto;
                dir_lat   <= dir_up;
                limit_lat <= limit;
                q         <= dir_up ? '0 : limit;
                state     <= S_RUN;
            end else begin
                case (state)
                    S_IDLE: ;
                    S_RUN: begin
                        if (stop) begin
                            q     <= '0;
                            state <= S_IDLE;
                        end else if (pause && !start) begin
                            state <= S_HOLD;
                        end else if (tick) begin
                            if (at_term) begin
                                tc <= 1'b1;
                                if (mode_lat) begin
                                    q <= dir_lat ? '0 : limit_lat;
                                end else begin
                                    state <= S_DONE;
                                end
                            end else begin
                                q <= dir_lat ? q + 1'b1 : q - 1'b1;
                            end
                        end
                    end
                    S_HOLD: begin
                        if (stop) begin
                            q     <= '0;
                            state <= S_IDLE;
                        end else if (!pause) begin
                            state <= S_RUN;
                        end
                    end
                    S_DONE: begin
                        if (stop) begin
                            q     <= '0;
                            state <= S_IDLE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_counter_ctrl.sv
// Bench for counter_ctrl: per-cycle vector table plus reset and prescaler sequences.
module tb_counter_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0, stop = 1'b0, pause = 1'b0;
    logic       mode_auto = 1'b0, dir_up = 1'b0;
    logic [3:0] limit = '0, prescale = '0;
    logic [3:0] q;
    logic       busy, tc, done;

    int n_cmp = 0;
    int n_bad = 0;
    logic [3:0] pre_sel = 4'd0;

    typedef struct {
        logic       s, st, p, a, u;
        logic [3:0] lim;
        logic [3:0] eq;
        logic       eb, et, ed;
    } vec_t;

    typedef struct packed {
        logic [3:0] q;
        logic       busy, tc, done;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    counter_ctrl #(.WIDTH(4), .PRE_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
        .mode_auto(mode_auto), .dir_up(dir_up), .limit(limit), .prescale(prescale),
        .q(q), .busy(busy), .tc(tc), .done(done)
    );

    always #5 clk = ~clk;

    function automatic void add(logic s, logic st, logic p, logic a, logic u, logic [3:0] lim,
                                logic [3:0] eq, logic eb, logic et, logic ed);
        vec_t v;
        v.s = s; v.st = st; v.p = p; v.a = a; v.u = u; v.lim = lim;
        v.eq = eq; v.eb = eb; v.et = et; v.ed = ed;
        vecs.push_back(v);
    endfunction

    task automatic expect_now(logic [3:0] eq, logic eb, logic et, logic ed);
        exp_t e;
        e.q = eq; e.busy = eb; e.tc = et; e.done = ed;
        sb.push_back(e);
    endtask

    task automatic check(string nm);
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: scoreboard empty", nm);
        end else begin
            e = sb.pop_front();
            n_cmp++;
            if ({q, busy, tc, done} !== e) begin
                n_bad++;
                $display("FAIL %s: got q=%0d busy=%b tc=%b done=%b, want q=%0d busy=%b tc=%b done=%b",
                         nm, q, busy, tc, done, e.q, e.busy, e.tc, e.done);
            end
        end
    endtask

    // Drive one edge's inputs; config inputs are scrambled whenever start is low
    // since only a start may capture them.
    task automatic apply(vec_t v, string nm);
        start = v.s; stop = v.st; pause = v.p;
        if (v.s) begin
            mode_auto = v.a; dir_up = v.u; limit = v.lim; prescale = pre_sel;
        end else begin
            mode_auto = 1'($urandom); dir_up = 1'($urandom);
            limit = 4'($urandom); prescale = 4'($urandom);
        end
        expect_now(v.eq, v.eb, v.et, v.ed);
        @(posedge clk);
        #1;
        check(nm);
    endtask

    initial begin
        vec_t v;
        logic [3:0] pq [9];
        logic       pt [9];
        logic       pp [9];

        // Up, auto-reload, limit 3
        add(1,0,0,1,1,3, 0,1,0,0);
        add(0,0,0,0,0,0, 1,1,0,0); add(0,0,0,0,0,0, 2,1,0,0); add(0,0,0,0,0,0, 3,1,0,0);
        add(0,0,0,0,0,0, 0,1,1,0); add(0,0,0,0,0,0, 1,1,0,0); add(0,0,0,0,0,0, 2,1,0,0);
        add(0,0,0,0,0,0, 3,1,0,0); add(0,0,0,0,0,0, 0,1,1,0); add(0,0,0,0,0,0, 1,1,0,0);
        add(0,1,0,0,0,0, 0,0,0,0);
        // Down, one-shot, limit 5 then restart from DONE with limit 2
        add(1,0,0,0,0,5, 5,1,0,0);
        for (int i = 4; i >= 0; i--) add(0,0,0,0,0,0, 4'(i),1,0,0);
        add(0,0,0,0,0,0, 0,0,1,1); add(0,0,0,0,0,0, 0,0,0,1); add(0,0,0,0,0,0, 0,0,0,1);
        add(1,0,0,0,0,2, 2,1,0,0); add(0,0,0,0,0,0, 1,1,0,0); add(0,0,0,0,0,0, 0,1,0,0);
        add(0,0,0,0,0,0, 0,0,1,1); add(0,0,0,0,0,0, 0,0,0,1);
        add(0,1,0,0,0,0, 0,0,0,0);
        // Down, auto-reload, limit 2
        add(1,0,0,1,0,2, 2,1,0,0); add(0,0,0,0,0,0, 1,1,0,0); add(0,0,0,0,0,0, 0,1,0,0);
        add(0,0,0,0,0,0, 2,1,1,0); add(0,0,0,0,0,0, 1,1,0,0);
        add(0,1,0,0,0,0, 0,0,0,0);
        // Pause at q=4 for three cycles, limit 7
        add(1,0,0,1,1,7, 0,1,0,0);
        for (int i = 1; i <= 4; i++) add(0,0,0,0,0,0, 4'(i),1,0,0);
        for (int i = 0; i < 3; i++) add(0,0,1,0,0,0, 4,1,0,0);
        add(0,0,0,0,0,0, 4,1,0,0);
        add(0,0,0,0,0,0, 5,1,0,0); add(0,0,0,0,0,0, 6,1,0,0); add(0,0,0,0,0,0, 7,1,0,0);
        add(0,0,0,0,0,0, 0,1,1,0);
        add(0,1,0,0,0,0, 0,0,0,0);
        // stop + start + pause together, then stop on a terminal tick
        add(1,0,0,1,1,7, 0,1,0,0); add(0,0,0,0,0,0, 1,1,0,0); add(0,0,0,0,0,0, 2,1,0,0);
        add(1,1,1,1,1,7, 0,0,0,0); add(0,0,0,0,0,0, 0,0,0,0);
        add(1,0,0,1,1,1, 0,1,0,0); add(0,0,0,0,0,0, 1,1,0,0);
        add(0,1,0,0,0,0, 0,0,0,0); add(0,0,0,0,0,0, 0,0,0,0);
        // limit 0: auto then one-shot
        add(1,0,0,1,1,0, 0,1,0,0);
        for (int i = 0; i < 3; i++) add(0,0,0,0,0,0, 0,1,1,0);
        add(0,1,0,0,0,0, 0,0,0,0);
        add(1,0,0,0,1,0, 0,1,0,0); add(0,0,0,0,0,0, 0,0,1,1); add(0,0,0,0,0,0, 0,0,0,1);
        add(0,1,0,0,0,0, 0,0,0,0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        expect_now(0, 0, 0, 0);
        check("reset_state");
        rst = 1'b1;

        foreach (vecs[i]) begin
            v = vecs[i];
            apply(v, $sformatf("vec%0d", i));
        end

        // Asynchronous reset mid-run at q=2
        add(1,0,0,1,1,7, 0,1,0,0);
        add(0,0,0,0,0,0, 1,1,0,0);
        add(0,0,0,0,0,0, 2,1,0,0);
        for (int i = vecs.size() - 3; i < vecs.size(); i++) begin
            v = vecs[i];
            apply(v, $sformatf("arst_pre%0d", i));
        end
        #2;
        rst = 1'b0;
        #1;
        expect_now(0, 0, 0, 0);
        check("async_reset");
        @(posedge clk);
        #1;
        rst = 1'b1;
        v = vecs[0];
        v.s = 0; v.eq = 0; v.eb = 0; v.et = 0; v.ed = 0;
        apply(v, "after_reset_idle");

        // Prescale 2 with a pause in the middle of a prescaler period
        pp = '{0,0,0,0,1,1,0,0,0};
`ifdef CNT_CTRL_PRESCALE_EN
        pq = '{0,0,1,1,1,1,1,1,2};
        pt = '{0,0,0,0,0,0,0,0,0};
`else
        pq = '{1,2,3,0,0,0,0,1,2};
        pt = '{0,0,0,1,0,0,0,0,0};
`endif
        pre_sel = 4'd2;
        v.s = 1; v.st = 0; v.p = 0; v.a = 1; v.u = 1; v.lim = 3;
        v.eq = 0; v.eb = 1; v.et = 0; v.ed = 0;
        apply(v, "pre_start");
        for (int i = 0; i < 9; i++) begin
            v.s = 0; v.p = pp[i];
            v.eq = pq[i]; v.eb = 1; v.et = pt[i]; v.ed = 0;
            apply(v, $sformatf("pre_e%0d", i + 1));
        end
        v.s = 0; v.st = 1; v.p = 0; v.eq = 0; v.eb = 0; v.et = 0; v.ed = 0;
        apply(v, "pre_stop");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
